// File: rtl/shift_serializer_if.sv
// Parallel-load / serial-out bus for shift_serializer.
// Master offers words and observes the serial stream.
interface shift_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             done;

    modport master (
        output load_valid,
        output data_in,
        input  load_ready,
        input  out,
        input  out_valid,
        input  done
    );

    modport slave (
        input  load_valid,
        input  data_in,
        output load_ready,
        output out,
        output out_valid,
        output done
    );
endinterface

// File: rtl/shift_serializer.sv
// LSB-first parallel-to-serial converter with back-to-back word loading.
// Define SHIFT_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module shift_serializer #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    input logic               shift,
    shift_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SHIFT_SERIALIZER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Next-state and output decode; a word accepted on the final
    // frame bit overrides the return to IDLE.
    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        par_d          = par_q;
`endif
        bus.out        = 1'b0;
        bus.out_valid  = 1'b0;
        bus.done       = 1'b0;
        bus.load_ready = 1'b0;
        accept         = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.out       = data_q[0];
                bus.out_valid = 1'b1;
`ifndef SHIFT_SERIALIZER_PARITY_EN
                bus.done       = (cnt_q == LAST) && shift;
                bus.load_ready = bus.done;
`endif
                if (shift) begin
                    if (cnt_q == LAST) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = {1'b0, data_q[WIDTH-1:1]};
                    end
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            PARITY: begin
                bus.out        = par_q;
                bus.out_valid  = 1'b1;
                bus.done       = shift;
                bus.load_ready = shift;
                if (shift) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = bus.load_valid && bus.load_ready;
        if (accept) begin
            state_d = SHIFT;
            data_d  = bus.data_in;
            cnt_d   = '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_d   = ^bus.data_in;
`endif
        end
    end

    // State, shift register and bit counter; reset discards any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_shift_serializer.sv
// Directed self-checking bench for shift_serializer (WIDTH=8).
// Expected serial bits are hand-derived from each loaded word.
module tb_shift_serializer;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk;
    logic reset;
    logic shift;
    int   tests;
    int   fails;

    shift_serializer_if #(.WIDTH(8)) bus ();

    shift_serializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .shift (shift),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".out"}, 8'(bus.out), 8'h0);
        chk({tag, ".valid"}, 8'(bus.out_valid), 8'h0);
        chk({tag, ".done"}, 8'(bus.done), 8'h0);
        chk({tag, ".ready"}, 8'(bus.load_ready), 8'h1);
    endtask

    // Word w was accepted on the last edge; walk its whole frame.
    // With chain set, nw is offered for the entire frame and must
    // only be taken on the final bit.
    task automatic send(input string tag, input logic [7:0] w,
                        input logic chain, input logic [7:0] nw);
        logic e;
        logic fin;
        for (int i = 0; i < FL; i++) begin
            e   = (i < 8) ? w[i] : ^w;
            fin = (i == FL - 1);
            bus.load_valid = chain;
            bus.data_in    = chain ? nw : ~w;
            #1;
            chk($sformatf("%s.b%0d.out", tag, i), 8'(bus.out), 8'(e));
            chk($sformatf("%s.b%0d.valid", tag, i),
                8'(bus.out_valid), 8'h1);
            chk($sformatf("%s.b%0d.done", tag, i), 8'(bus.done), 8'(fin));
            chk($sformatf("%s.b%0d.ready", tag, i),
                8'(bus.load_ready), 8'(fin));
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] w);
        bus.load_valid = 1'b1;
        bus.data_in    = w;
        tick();
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b1;
        shift          = 1'b1;
        bus.load_valid = 1'b0;
        bus.data_in    = 8'h00;
        tick();
        chk_idle("rst");

        // Reset wins over a simultaneous load.
        bus.load_valid = 1'b1;
        bus.data_in    = 8'h55;
        tick();
        chk_idle("rst_prio");

        // Basic frame, B2 -> 0,1,0,0,1,1,0,1.
        reset = 1'b0;
        load(8'hB2);
        send("b2", 8'hB2, 1'b0, 8'h00);
        #1;
        chk_idle("b2_end");

        // Back-to-back FF then 00 with no gap.
        load(8'hFF);
        send("ff", 8'hFF, 1'b1, 8'h00);
        send("z0", 8'h00, 1'b0, 8'h00);
        #1;
        chk_idle("b2b_end");

        // Stall three cycles on bit 0 of 01.
        load(8'h01);
        bus.load_valid = 1'b0;
        shift          = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d.out", k), 8'(bus.out), 8'h1);
            chk($sformatf("stall%0d.valid", k), 8'(bus.out_valid), 8'h1);
            chk($sformatf("stall%0d.done", k), 8'(bus.done), 8'h0);
            chk($sformatf("stall%0d.ready", k), 8'(bus.load_ready), 8'h0);
            tick();
        end
        shift = 1'b1;
        send("s01", 8'h01, 1'b0, 8'h00);
        #1;
        chk_idle("stall_end");

        // Reset during bit 4 of AA, then load 0F on the first edge.
        load(8'hAA);
        bus.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("aa.b%0d.out", i), 8'(bus.out), 8'(i % 2));
            tick();
        end
        chk("aa.b4.out", 8'(bus.out), 8'h0);
        chk("aa.b4.valid", 8'(bus.out_valid), 8'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("mid_rst");
        load(8'h0F);
        send("0f", 8'h0F, 1'b0, 8'h00);
        #1;
        chk_idle("0f_end");

`ifdef SHIFT_SERIALIZER_PARITY_EN
        load(8'h07);
        send("p07", 8'h07, 1'b1, 8'h03);
        send("p03", 8'h03, 1'b0, 8'h00);
        #1;
        chk_idle("par_end");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port shift, input, 1 bit: advance enable; 0 stalls the serial stream.
REQ-005 The block SHALL have port load_valid, input, 1 bit: a parallel word is offered on data_in.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: the parallel word to serialize.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port out, output, 1 bit: the serial data bit, compatible with the team's shift_register serial input.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out carries a frame bit this cycle.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the final frame bit.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, SHIFT and PARITY, where PARITY exists only when the macro of REQ-027 is defined.
REQ-012 A word SHALL be accepted on any rising edge where load_valid=1 and load_ready=1; data_in is captured into an internal WIDTH-bit register and the bit counter is cleared.
REQ-013 load_ready SHALL be 1 in IDLE, and 1 in the final frame cycle when shift=1; it SHALL be 0 otherwise.
REQ-014 After acceptance the next state SHALL be SHIFT, with out = data_in[0] (LSB first) and out_valid=1 in the cycle after acceptance, for one-cycle latency.
REQ-015 In SHIFT, when shift=1, the next rising edge SHALL advance to the next bit (bit k to bit k+1); when shift=0, out, out_valid, the counter and the register SHALL hold.
REQ-016 Bit WIDTH-1 SHALL be the final frame bit when no parity is configured; done SHALL equal 1 exactly while that bit is presented and shift=1.
REQ-017 On leaving the final frame bit (shift=1), the block SHALL enter SHIFT with the new word if a word is accepted in that same cycle (back-to-back, no gap cycle); otherwise it SHALL enter IDLE.
REQ-018 In IDLE, out SHALL be 0, out_valid 0 and done 0.
REQ-019 When load_valid=1 while load_ready=0, the block SHALL ignore data_in and the in-flight frame SHALL be unaffected.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.
REQ-021 Changes to data_in after acceptance SHALL NOT affect the in-flight frame.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL enter IDLE and clear the data register and counter, regardless of state; any frame in progress is discarded.
REQ-023 While in reset, the outputs SHALL take these values after the edge: out=0, out_valid=0, done=0, load_ready=1.
REQ-024 When reset and load_valid are both 1 on the same edge, reset SHALL take priority and no word is accepted.
REQ-025 On the first edge after reset deasserts, the block SHALL accept a word normally if load_valid=1.

Configuration
REQ-026 The block SHALL support exactly one optional feature, the parity bit.
REQ-027 With SHIFT_SERIALIZER_PARITY_EN defined: after bit WIDTH-1 (shift=1) the block SHALL enter PARITY and present out = XOR of the WIDTH data bits (even parity) with out_valid=1 and the stall rule of REQ-015; the parity cycle SHALL be the final frame bit for REQ-013, REQ-016 and REQ-017, so the frame is WIDTH+1 bits.
REQ-028 Without SHIFT_SERIALIZER_PARITY_EN: no PARITY state exists, and the frame SHALL be WIDTH bits.

Verification
REQ-029 WIDTH=8, shift=1, accept 8'hB2 -> out over the following 8 cycles = 0,1,0,0,1,1,0,1; out_valid=1 for those cycles; done=1 only on the 8th cycle; then IDLE with out=0.
REQ-030 Back-to-back: accept 8'hFF, hold load_valid=1 with 8'h00 -> 8 ones then 8 zeros, out_valid continuously 1, and load_ready=1 only on the final-bit cycles.
REQ-031 Stall: accept 8'h01, drop shift for 3 cycles during bit 0 -> out=1 held for 4 cycles, then 7 zeros; total out_valid cycles = 11.
REQ-032 Reset mid-frame: assert reset during bit 4 of 8'hAA -> next cycle out=0, out_valid=0, load_ready=1; a new 8'h0F then serializes correctly.
REQ-033 With SHIFT_SERIALIZER_PARITY_EN defined, accept 8'h07 -> 1,1,1,0,0,0,0,0, then parity 1; done only on the parity cycle; and 8'h03 -> parity 0.
REQ-034 Serializer out/shift connected to shift_register #(8) -> the register output reproduces the serialized stream delayed by 8 shifts.
